stopwatch_ctrl: RTL and testbench

Control FSM for the stopwatch datapath.
- Debounces the two raw pushbuttons and turns each press into a one-cycle pulse.
- Runs the IDLE/RUN/LAP/PAUSED state machine.
- Generates the gated centisecond count-enable tick, the counter clear pulse and the display-hold (lap freeze) for the time counters and the seven-segment driver.
- Sits between board buttons and the time counters; `at_max` comes back from the counters.

---
 rtl/stopwatch_ctrl_if.sv | 22 ++
 rtl/stopwatch_ctrl.sv | 145 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Button, counter-status and control-strobe bundle between the board and stopwatch_ctrl.
// The controller takes the slave view; the board/testbench takes the master view.
interface stopwatch_ctrl_if;
  logic       start_btn;
  logic       lap_btn;
  logic       at_max;
  logic       tick;
  logic       clr;
  logic       hold;
  logic       running;
  logic [1:0] state;

  modport master (
    output start_btn, lap_btn, at_max,
    input  tick, clr, hold, running, state
  );

  modport slave (
    input  start_btn, lap_btn, at_max,
    output tick, clr, hold, running, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button debounce, IDLE/RUN/LAP/PAUSED FSM, tick prescaler, clear and hold.
// Define STOPWATCH_LAP_EN to enable the LAP state and the hold output.
module stopwatch_ctrl #(
  parameter int CLK_DIV   = 1_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input logic            clk,
  input logic            reset,
  stopwatch_ctrl_if.slave sw
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    LAP    = 2'b11
  } state_t;

  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  // Button path, bit 0 = start, bit 1 = lap
  logic [1:0]    btn_raw;
  logic [1:0]    sync1, sync2;
  logic [1:0]    deb, deb_q;
  logic [DW-1:0] db_cnt [2];
  logic          start_p, lap_p;

  assign btn_raw = {sw.lap_btn, sw.start_btn};

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      // NOTE: the counter array is small control state, so it is reset like any other register.
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign start_p = deb[0] & ~deb_q[0];
  assign lap_p   = deb[1] & ~deb_q[1];

  // FSM
  state_t state_q, state_d;
  logic   clr_q, clr_d;
  logic   running;

  assign running = state_q[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_p) begin
          state_d = RUN;
        end else if (lap_p) begin
          clr_d = 1'b1;
        end
      end
      RUN: begin
        if (sw.at_max || start_p) begin
          state_d = PAUSED;
`ifdef STOPWATCH_LAP_EN
        end else if (lap_p) begin
          state_d = LAP;
`endif
        end
      end
      LAP: begin
        if (sw.at_max || start_p) begin
          state_d = PAUSED;
        end else if (lap_p) begin
          state_d = RUN;
        end
      end
      PAUSED: begin
        // A start press claims the cycle even when at_max blocks the resume.
        if (start_p) begin
          if (!sw.at_max) state_d = RUN;
        end else if (lap_p) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Prescaler keeps its phase across PAUSED so a resume continues the partial tick.
  logic [PW-1:0] presc;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (state_q == IDLE || clr_d) begin
      presc <= '0;
    end else if (running) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

  assign sw.tick    = running && (presc == PRESC_LAST) && !sw.at_max;
  assign sw.clr     = clr_q;
  assign sw.running = running;
  assign sw.state   = state_q;
`ifdef STOPWATCH_LAP_EN
  assign sw.hold    = (state_q == LAP);
`else
  assign sw.hold    = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with CLK_DIV=5, DB_CYCLES=4.
// Covers both builds; LAP-specific scenarios depend on STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  int   tick_cnt;
  int   clr_cnt;

  stopwatch_ctrl_if sw ();

  stopwatch_ctrl #(
    .CLK_DIV   (5),
    .DB_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sw.tick) tick_cnt++;
    if (sw.clr)  clr_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press held exactly long enough for the FSM to take the new state.
  task automatic press(input bit lap);
    if (lap) sw.lap_btn = 1'b1; else sw.start_btn = 1'b1;
    step(7);
    if (lap) sw.lap_btn = 1'b0; else sw.start_btn = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    tests_run++;
    if (sw.state !== 2'b00) begin tests_failed++; $display("FAIL reset_state: got %b expected 00", sw.state); end
    tests_run++;
    if ({sw.tick, sw.clr, sw.hold, sw.running} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: tick/clr/hold/running got %b expected 0000", {sw.tick, sw.clr, sw.hold, sw.running});
    end
  endtask

  task automatic test_debounce;
    clr_cnt = 0;
    sw.lap_btn = 1'b1;
    step(3);
    sw.lap_btn = 1'b0;
    step(10);
    tests_run++;
    if (clr_cnt !== 0) begin tests_failed++; $display("FAIL glitch_no_clr: got %0d clr pulses expected 0", clr_cnt); end
    tests_run++;
    if (sw.state !== 2'b00) begin tests_failed++; $display("FAIL glitch_state: got %b expected 00", sw.state); end

    clr_cnt = 0;
    press(1'b1);
    tests_run++;
    if (sw.clr !== 1'b1) begin tests_failed++; $display("FAIL idle_lap_clr: got %b expected 1", sw.clr); end
    step(6);
    tests_run++;
    if (clr_cnt !== 1) begin tests_failed++; $display("FAIL idle_lap_clr_count: got %0d expected 1", clr_cnt); end
    tests_run++;
    if (sw.state !== 2'b00) begin tests_failed++; $display("FAIL idle_lap_state: got %b expected 00", sw.state); end

    sw.start_btn = 1'b1;
    step(5);
    tests_run++;
    if (sw.state !== 2'b00) begin tests_failed++; $display("FAIL debounce_early: got %b expected 00", sw.state); end
    step(2);
    tests_run++;
    if (sw.state !== 2'b01) begin tests_failed++; $display("FAIL debounce_run: got %b expected 01", sw.state); end
    step(10);
    tests_run++;
    if (sw.state !== 2'b01) begin tests_failed++; $display("FAIL single_pulse: got %b expected 01", sw.state); end
    sw.start_btn = 1'b0;
    step(8);
    // Return to IDLE via PAUSED and a lap press
    press(1'b0);
    step(6);
    press(1'b1);
    step(6);
  endtask

  task automatic test_run;
    press(1'b0);
    tests_run++;
    if ({sw.state, sw.running, sw.hold, sw.tick} !== 5'b01100) begin
      tests_failed++;
      $display("FAIL run_entry: state/running/hold/tick got %b expected 01100", {sw.state, sw.running, sw.hold, sw.tick});
    end
    step(3);
    tests_run++;
    if (sw.tick !== 1'b0) begin tests_failed++; $display("FAIL run_cycle4_tick: got %b expected 0", sw.tick); end
    step(1);
    tests_run++;
    if (sw.tick !== 1'b1) begin tests_failed++; $display("FAIL run_first_tick: got %b expected 1", sw.tick); end
    tick_cnt = 0;
    step(20);
    tests_run++;
    if (tick_cnt !== 4) begin tests_failed++; $display("FAIL run_tick_count: got %0d expected 4", tick_cnt); end
  endtask

  task automatic test_pause_resume;
    step(1);
    press(1'b0);  // pause after 32 RUN cycles, prescaler = 2
    tests_run++;
    if ({sw.state, sw.running} !== 3'b100) begin
      tests_failed++;
      $display("FAIL pause_state: state/running got %b expected 100", {sw.state, sw.running});
    end
    tick_cnt = 0;
    step(20);
    tests_run++;
    if (tick_cnt !== 0) begin tests_failed++; $display("FAIL pause_no_tick: got %0d expected 0", tick_cnt); end

    press(1'b0);
    tests_run++;
    if (sw.tick !== 1'b0) begin tests_failed++; $display("FAIL resume_cycle1: got %b expected 0", sw.tick); end
    step(1);
    tests_run++;
    if (sw.tick !== 1'b0) begin tests_failed++; $display("FAIL resume_cycle2: got %b expected 0", sw.tick); end
    step(1);
    tests_run++;
    if (sw.tick !== 1'b1) begin tests_failed++; $display("FAIL resume_cycle3_tick: got %b expected 1", sw.tick); end

    step(4);
    press(1'b0);
    step(6);
    press(1'b1);
    tests_run++;
    if ({sw.clr, sw.state} !== 3'b100) begin
      tests_failed++;
      $display("FAIL paused_lap_clr: clr/state got %b expected 100", {sw.clr, sw.state});
    end
    step(1);
    tests_run++;
    if (sw.clr !== 1'b0) begin tests_failed++; $display("FAIL clr_one_cycle: got %b expected 0", sw.clr); end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap;
    step(6);
    press(1'b0);
    step(4);
    tests_run++;
    if (sw.tick !== 1'b1) begin tests_failed++; $display("FAIL prescaler_cleared_tick: got %b expected 1", sw.tick); end
    step(1);
    press(1'b1);
    tests_run++;
    if ({sw.state, sw.hold, sw.running} !== 4'b1111) begin
      tests_failed++;
      $display("FAIL lap_enter: state/hold/running got %b expected 1111", {sw.state, sw.hold, sw.running});
    end
    step(2);
    tests_run++;
    if (sw.tick !== 1'b1) begin tests_failed++; $display("FAIL lap_tick: got %b expected 1", sw.tick); end
    step(4);
    press(1'b1);
    tests_run++;
    if ({sw.state, sw.hold} !== 3'b010) begin
      tests_failed++;
      $display("FAIL lap_exit: state/hold got %b expected 010", {sw.state, sw.hold});
    end
  endtask
`else
  task automatic test_lap_disabled;
    step(6);
    press(1'b0);
    step(4);
    tests_run++;
    if (sw.tick !== 1'b1) begin tests_failed++; $display("FAIL prescaler_cleared_tick: got %b expected 1", sw.tick); end
    step(1);
    press(1'b1);
    tests_run++;
    if ({sw.state, sw.hold} !== 3'b010) begin
      tests_failed++;
      $display("FAIL lap_ignored: state/hold got %b expected 010", {sw.state, sw.hold});
    end
    step(2);
    tests_run++;
    if (sw.tick !== 1'b1) begin tests_failed++; $display("FAIL run_tick_after_lap: got %b expected 1", sw.tick); end
    step(4);
    press(1'b1);
    tests_run++;
    if (sw.state !== 2'b01) begin tests_failed++; $display("FAIL lap_ignored_again: got %b expected 01", sw.state); end
  endtask
`endif

  task automatic test_priority;
    step(5);
    sw.start_btn = 1'b1;
    sw.lap_btn   = 1'b1;
    step(7);
    sw.start_btn = 1'b0;
    sw.lap_btn   = 1'b0;
    tests_run++;
    if ({sw.state, sw.hold} !== 3'b100) begin
      tests_failed++;
      $display("FAIL start_lap_same_cycle: state/hold got %b expected 100", {sw.state, sw.hold});
    end

    step(6);
    press(1'b0);  // resume, prescaler starts at 2
    step(2);
    sw.at_max = 1'b1;
    #1;
    tests_run++;
    if (sw.tick !== 1'b0) begin tests_failed++; $display("FAIL at_max_blocks_tick: got %b expected 0", sw.tick); end
    step(1);
    tests_run++;
    if ({sw.state, sw.running} !== 3'b100) begin
      tests_failed++;
      $display("FAIL at_max_pause: state/running got %b expected 100", {sw.state, sw.running});
    end
    step(5);
    press(1'b0);
    tests_run++;
    if (sw.state !== 2'b10) begin tests_failed++; $display("FAIL start_at_max_ignored: got %b expected 10", sw.state); end
    sw.at_max = 1'b0;
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap_at_max_reset;
    step(6);
    press(1'b0);  // prescaler resumes at 0
    step(7);
    press(1'b1);  // LAP entered with prescaler = 4
    tests_run++;
    if ({sw.state, sw.tick} !== 3'b111) begin
      tests_failed++;
      $display("FAIL lap_setup: state/tick got %b expected 111", {sw.state, sw.tick});
    end
    sw.at_max = 1'b1;
    #1;
    tests_run++;
    if (sw.tick !== 1'b0) begin tests_failed++; $display("FAIL lap_at_max_tick: got %b expected 0", sw.tick); end
    step(1);
    tests_run++;
    if ({sw.state, sw.hold} !== 3'b100) begin
      tests_failed++;
      $display("FAIL lap_at_max_pause: state/hold got %b expected 100", {sw.state, sw.hold});
    end
    sw.at_max = 1'b0;

    step(6);
    press(1'b0);
    step(6);
    press(1'b1);
    tests_run++;
    if (sw.state !== 2'b11) begin tests_failed++; $display("FAIL reset_setup_lap: got %b expected 11", sw.state); end
    reset = 1'b1;
    step(1);
    tests_run++;
    if ({sw.state, sw.tick, sw.clr, sw.hold, sw.running} !== 6'b000000) begin
      tests_failed++;
      $display("FAIL reset_in_lap: state/tick/clr/hold/running got %b expected 000000",
               {sw.state, sw.tick, sw.clr, sw.hold, sw.running});
    end
    reset = 1'b0;
    step(2);
  endtask
`else
  task automatic test_reset_in_run;
    step(6);
    press(1'b0);
    tests_run++;
    if (sw.state !== 2'b01) begin tests_failed++; $display("FAIL reset_setup_run: got %b expected 01", sw.state); end
    reset = 1'b1;
    step(1);
    tests_run++;
    if ({sw.state, sw.tick, sw.clr, sw.hold, sw.running} !== 6'b000000) begin
      tests_failed++;
      $display("FAIL reset_in_run: state/tick/clr/hold/running got %b expected 000000",
               {sw.state, sw.tick, sw.clr, sw.hold, sw.running});
    end
    reset = 1'b0;
    step(2);
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    tick_cnt     = 0;
    clr_cnt      = 0;
    reset        = 1'b1;
    sw.start_btn = 1'b0;
    sw.lap_btn   = 1'b0;
    sw.at_max    = 1'b0;

    test_reset();
    test_debounce();
    test_run();
    test_pause_resume();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`else
    test_lap_disabled();
`endif
    test_priority();
`ifdef STOPWATCH_LAP_EN
    test_lap_at_max_reset();
`else
    test_reset_in_run();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
